// File: rtl/axis_if.sv
// AXI-stream style handshake bundle: data with vld/rdy and the derived transfer strobe ok.
interface axis_if #(
    parameter type T = logic [23:0]
);
    T     data;
    logic vld;
    logic rdy;
    logic ok;

    assign ok = vld & rdy;

    modport master (output data, output vld, input rdy, input ok);
    modport slave  (input data, input vld, input ok, output rdy);
endinterface

// File: rtl/echo_delay.sv
// Delay/echo stage: y = dry + mix*delayed, buffer gets dry + feedback*delayed.
// A circular BRAM of 2^ADDR_WIDTH words is zeroed after every reset.
module echo_delay #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 14,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_if.slave                 axis_in,
    axis_if.master                axis_out,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    input  logic [GAIN_WIDTH-1:0] mix_gain,
    input  logic                  bypass
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int SUM_W  = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_CALC  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic        [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic        [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic        [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic signed [DATA_WIDTH-1:0]   x_q, x_d;
    logic                           dly_zero_q, dly_zero_d;
    logic        [GAIN_WIDTH-1:0]   fb_q, fb_d;
    logic        [GAIN_WIDTH-1:0]   mix_q, mix_d;
    logic                           byp_q, byp_d;
    logic                           in_rdy_q, in_rdy_d;
    logic                           out_vld_q, out_vld_d;
    logic        [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic signed [DATA_WIDTH-1:0]   rd_data_q;
    logic        [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                           mem_we_s;
    logic        [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic        [DATA_WIDTH-1:0]   mem_wdata_s;
    logic signed [DATA_WIDTH-1:0]   d_s;
    logic        [DATA_WIDTH-1:0]   y_s;
    logic        [DATA_WIDTH-1:0]   w_s;

    // x + floor(d*g/2^GAIN_WIDTH), saturated to the signed sample range
    function automatic logic [DATA_WIDTH-1:0] scaled_sum(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] d,
        input logic        [GAIN_WIDTH-1:0] g
    );
        logic signed [GAIN_WIDTH:0] gs;
        logic signed [PROD_W-1:0]   prod;
        logic signed [SUM_W-1:0]    sum;
        gs   = $signed({1'b0, g});
        prod = PROD_W'(d) * PROD_W'(gs);
        prod = prod >>> GAIN_WIDTH;
        sum  = SUM_W'(x) + SUM_W'(prod);
        if (sum[SUM_W-1:DATA_WIDTH-1] == {(SUM_W-DATA_WIDTH+1){sum[SUM_W-1]}}) begin
            scaled_sum = sum[DATA_WIDTH-1:0];
        end else if (sum[SUM_W-1]) begin
            scaled_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            scaled_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    assign d_s = dly_zero_q ? {DATA_WIDTH{1'b0}} : rd_data_q;
    assign y_s = scaled_sum(x_q, d_s, mix_q);
    assign w_s = scaled_sum(x_q, d_s, fb_q);

    assign axis_in.rdy   = in_rdy_q;
    assign axis_out.vld  = out_vld_q;
    assign axis_out.data = out_data_q;

    // Next-state, buffer write port and registered-output decode
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_addr_d   = rd_addr_q;
        x_d         = x_q;
        dly_zero_d  = dly_zero_q;
        fb_d        = fb_q;
        mix_d       = mix_q;
        byp_d       = byp_q;
        out_data_d  = out_data_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_ptr_q;
        mem_wdata_s = w_s;
        case (state_q)
            S_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = {DATA_WIDTH{1'b0}};
                clr_cnt_d   = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_IDLE: begin
                if (axis_in.ok) begin
                    x_d        = axis_in.data;
                    dly_zero_d = (delay == {ADDR_WIDTH{1'b0}});
                    fb_d       = fb_gain;
                    mix_d      = mix_gain;
                    byp_d      = bypass;
                    rd_addr_d  = wr_ptr_q - delay;
                    state_d    = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = wr_ptr_q;
                mem_wdata_s = w_s;
                wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
                out_data_d  = byp_q ? x_q : y_s;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (axis_out.ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
        in_rdy_d  = (state_d == S_IDLE);
        out_vld_d = (state_d == S_OUT);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= {ADDR_WIDTH{1'b0}};
            wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
            rd_addr_q  <= {ADDR_WIDTH{1'b0}};
            x_q        <= {DATA_WIDTH{1'b0}};
            dly_zero_q <= 1'b0;
            fb_q       <= {GAIN_WIDTH{1'b0}};
            mix_q      <= {GAIN_WIDTH{1'b0}};
            byp_q      <= 1'b0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_addr_q  <= rd_addr_d;
            x_q        <= x_d;
            dly_zero_q <= dly_zero_d;
            fb_q       <= fb_d;
            mix_q      <= mix_d;
            byp_q      <= byp_d;
            in_rdy_q   <= in_rdy_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    // Buffer write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Buffer read port; address is registered in IDLE so data lands in CALC
    always_ff @(posedge clk) begin
        rd_data_q <= mem[rd_addr_q];
    end
endmodule

// File: doc/echo_delay.md
Name: echo_delay

Overview:
Digital delay/echo effect stage. Consumes 24-bit samples from the I2S core's receive AXI-stream (ADC side) and produces processed samples for the I2S core's transmit AXI-stream (DAC side). A BRAM circular buffer holds past samples. Output is dry + mix·delayed; the value written back to the buffer is dry + feedback·delayed. Samples are processed as one interleaved stream, so software programs even delay values to keep L/R alignment.

Parameters:
DATA_WIDTH, 24, sample width, signed two's complement
ADDR_WIDTH, 14, buffer address width; depth = 2^ADDR_WIDTH words
GAIN_WIDTH, 8, unsigned gain width; gain is Q0.8 (value/256)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous, active-high reset
axis_in  slave  axis_if #(logic [DATA_WIDTH-1:0])  dry samples from I2S rx; uses data/vld/rdy/ok
axis_out  master  axis_if #(logic [DATA_WIDTH-1:0])  wet samples to I2S tx
delay  input  ADDR_WIDTH  echo delay in stream words, sampled at input handshake
fb_gain  input  GAIN_WIDTH  feedback gain, Q0.8
mix_gain  input  GAIN_WIDTH  wet mix gain, Q0.8
bypass  input  1  1 = output equals dry input, sampled at input handshake

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. It forces state CLEAR and sets wr_ptr=0, axis_in.rdy=0, axis_out.vld=0, axis_out.data=0. Any in-flight sample is dropped. Reset acts from any state.
- Handshake: ok = vld & rdy. A master holds data and vld stable until ok.
- FSM states and transitions:
  - CLEAR: writes 0 to buffer[clr_cnt] each cycle for 2^ADDR_WIDTH cycles. axis_in.rdy=0. Goes to IDLE after the last address.
  - IDLE: axis_in.rdy=1. On axis_in.ok, latches x, delay, gains and bypass, drives read addr = (wr_ptr - delay) mod 2^ADDR_WIDTH, then goes to READ.
  - READ: one cycle of BRAM read latency. rdy=0.
  - CALC: d = buffer output. If the latched delay == 0, d is forced to 0.
    - y = sat(x + ((d * mix_gain) >>> 8))
    - w = sat(x + ((d * fb_gain) >>> 8))
    - Writes buffer[wr_ptr] = w, sets wr_ptr = wr_ptr+1 (wraps 2^A-1 -> 0), registers axis_out.data = bypass ? x : y, then goes to OUT.
  - OUT: axis_out.vld=1, data stable, axis_in.rdy=0. On axis_out.ok, vld drops the next cycle and the FSM returns to IDLE.
- Arithmetic:
  - Gains are zero-extended to signed GAIN_WIDTH+1 bits.
  - Product is DATA_WIDTH+GAIN_WIDTH+1 bits signed; the shift is arithmetic (floor).
  - Sum is formed in DATA_WIDTH+2 bits, then saturated to [-2^23, 2^23-1].
  - Gain 255 is the maximum, giving ~0.996.
- Bypass: affects only the output. The buffer is still written with w, so toggling bypass is glitch-free.
- Latency and throughput:
  - axis_in.ok at cycle N gives axis_out.vld=1 at cycle N+3.
  - Minimum 4 cycles per sample, which leaves large headroom over the 48 kHz × 2 channel rate.
- Delay wrap: read address arithmetic is modulo 2^ADDR_WIDTH. delay=1 reads the previous sample.
- Backpressure: axis_out.rdy low holds the FSM in OUT indefinitely. No input is accepted meanwhile; the I2S core absorbs the stall.
- Parameter updates: changing delay or gains mid-sample has no effect until the next input handshake.

Test Plan:
- Reset/clear: release rst -> axis_in.rdy=0 for exactly 16384 cycles, then 1; axis_out.vld stays 0 throughout; readback of any delayed sample after clear is 0.
- Impulse, delay=4, fb=0, mix=128: inputs 1048576,0,0,0,0,0,... -> outputs 1048576,0,0,0,524288,0,0,0,0 (no repeat); vld at N+3 for each input.
- Feedback, delay=4, fb=128, mix=255: same impulse -> out[4]=1044480, out[8]=522240, out[12]=261120; other outputs 0.
- Saturation, delay=1, mix=255, fb=255:
  - Input 8388592 twice -> second output 8388607.
  - Input -8388608 twice -> second output -8388608.
- Backpressure: hold axis_out.rdy=0 for 10 cycles with vld=1 -> data unchanged and axis_in.rdy=0 throughout; sample accepted on release with no loss or duplication over 100 random samples vs reference model.
- Bypass / delay=0 / reset mid-op:
  - bypass=1 -> output equals input bit-exact.
  - delay=0 -> output equals x.
  - rst asserted in OUT -> vld=0 next cycle, CLEAR rerun, wr_ptr=0.
